// File: rtl/dm_wait_responder_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
// Holds the FSM state encoding and the latched-request record.
package dm_wait_responder_pkg;

  localparam int DM_DEPTH           = 10;
  localparam int DMBE_WIDTH         = 4;
  localparam int DMRSP_WAIT_DEFAULT = 2;
  localparam int DMRSP_CNT_W        = 4;   // wide enough for WAIT_CYC up to 15

  typedef enum logic [1:0] {
    DMRSP_IDLE = 2'b00,
    DMRSP_WAIT = 2'b01,
    DMRSP_DONE = 2'b10
  } dmrsp_state_e;

  typedef struct packed {
    logic                  we;
    logic [DMBE_WIDTH-1:0] be;
    logic [31:0]           wdata;
  } dm_wr_t;

endpackage

// File: rtl/dm_wait_responder_if.sv
// M-stage data-memory port: request/byte-enable/data towards memory, read word,
// ack and stall back towards the pipeline.
interface dm_wait_responder_if
  import dm_wait_responder_pkg::*;
#(
  parameter int DEPTH = DM_DEPTH
);

  logic                  req;
  logic                  we;
  logic [DEPTH-1:0]      addr;
  logic [DMBE_WIDTH-1:0] be;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  ack;
  logic                  stall;

  modport master (
    output req, we, addr, be, wdata,
    input  rdata, ack, stall
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output rdata, ack, stall
  );

endinterface

// File: rtl/dm_bank.sv
// 2**DEPTH x 32-bit word array with per-byte-lane write enables and a
// registered read port that holds its value between reads.
module dm_bank
  import dm_wait_responder_pkg::*;
#(
  parameter int DEPTH = DM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DEPTH-1:0]      addr,
  input  logic [DMBE_WIDTH-1:0] be,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<DEPTH)-1];

  // NOTE: the array is deliberately left out of reset so it maps onto RAM;
  // only the read register is reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DMBE_WIDTH; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata <= '0;
    else if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/dm_wait_responder.sv
// Data-memory responder that accepts one access, waits WAIT_CYC cycles, commits it
// and pulses ack; stall freezes the pipeline until that ack.
module dm_wait_responder
  import dm_wait_responder_pkg::*;
#(
  parameter int DEPTH    = DM_DEPTH,
  parameter int WAIT_CYC = DMRSP_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  dm_wait_responder_if.slave bus
);

  localparam logic [DMRSP_CNT_W-1:0] CNT_INIT =
    (WAIT_CYC == 0) ? '0 : DMRSP_CNT_W'(WAIT_CYC - 1);

  dmrsp_state_e           state;
  logic [DMRSP_CNT_W-1:0] cnt;
  dm_wr_t                 lat;
  logic [DEPTH-1:0]       lat_addr;
  logic                   ack_q;

  dm_wr_t                 cur;
  logic [DEPTH-1:0]       cur_addr;
  logic                   commit;

  // The commit edge is the one entering DONE. With zero wait cycles that is the
  // acceptance edge itself, so the live inputs are used instead of the latch.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    commit   = 1'b0;
    cur      = lat;
    cur_addr = lat_addr;
    unique case (state)
      DMRSP_IDLE: begin
        cur      = '{we: bus.we, be: bus.be, wdata: bus.wdata};
        cur_addr = bus.addr;
        commit   = bus.req && (WAIT_CYC == 0);
      end
      DMRSP_WAIT: commit = (cnt == '0);
      default:    commit = 1'b0;
    endcase
    commit = commit & rst_n;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DMRSP_IDLE;
      cnt      <= '0;
      lat      <= '0;
      lat_addr <= '0;
      ack_q    <= 1'b0;
    end else begin
      unique case (state)
        DMRSP_IDLE: begin
          ack_q <= 1'b0;
          if (bus.req) begin
            lat      <= '{we: bus.we, be: bus.be, wdata: bus.wdata};
            lat_addr <= bus.addr;
            if (WAIT_CYC == 0) begin
              state <= DMRSP_DONE;
              ack_q <= 1'b1;
            end else begin
              cnt   <= CNT_INIT;
              state <= DMRSP_WAIT;
            end
          end
        end
        DMRSP_WAIT: begin
          if (cnt == '0) begin
            state <= DMRSP_DONE;
            ack_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DMRSP_DONE: begin
          // A request seen here belongs to the next M-stage instruction.
          ack_q <= 1'b0;
          state <= DMRSP_IDLE;
        end
        default: begin
          ack_q <= 1'b0;
          state <= DMRSP_IDLE;
        end
      endcase
    end
  end

  assign bus.ack   = ack_q;
  assign bus.stall = bus.req & ~ack_q;

  dm_bank #(.DEPTH(DEPTH)) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (commit & cur.we),
    .rd_en (commit & ~cur.we),
    .addr  (cur_addr),
    .be    (cur.be),
    .wdata (cur.wdata),
    .rdata (bus.rdata)
  );

endmodule

// File: tb/tb_dm_wait_responder.sv
// Bench for dm_wait_responder: a WAIT_CYC=2 and a WAIT_CYC=0 instance, scoreboarded
// against a word-array model with expected ack cycles.
module tb_dm_wait_responder;
  import dm_wait_responder_pkg::*;

  localparam int DEPTH = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_wait_responder_if #(.DEPTH(DEPTH)) bus_a ();
  dm_wait_responder_if #(.DEPTH(DEPTH)) bus_b ();

  dm_wait_responder #(.DEPTH(DEPTH), .WAIT_CYC(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
  );
  dm_wait_responder #(.DEPTH(DEPTH), .WAIT_CYC(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] mem_a[int];
  logic [31:0] mem_b[int];
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: stall rule every cycle, and every ack is matched to the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("stall_a", 32'(bus_a.stall), 32'(bus_a.req & ~bus_a.ack));
      if (bus_a.ack) begin
        if (q_a.size() == 0) check("unexpected_ack_a", 32'(bus_a.ack), 32'd0);
        else begin
          e = q_a.pop_front();
          check("rdata_a", bus_a.rdata, e.data);
          check("ack_cycle_a", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("stall_b", 32'(bus_b.stall), 32'(bus_b.req & ~bus_b.ack));
      if (bus_b.ack) begin
        if (q_b.size() == 0) check("unexpected_ack_b", 32'(bus_b.ack), 32'd0);
        else begin
          e = q_b.pop_front();
          check("rdata_b", bus_b.rdata, e.data);
          check("ack_cycle_b", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Issues one access on instance d (0: WAIT_CYC=2, 1: WAIT_CYC=0), starting at
  // posedge+1 and returning at posedge+1 of the cycle after ack.
  task automatic access(input bit d, input bit w, input logic [DEPTH-1:0] a,
                        input logic [3:0] b, input logic [31:0] wd, input bit keep);
    exp_t        e;
    logic [31:0] old;
    int          n;
    e.cyc = cyc + (d ? 1 : 3);
    if (!d) begin
      bus_a.req = 1'b1; bus_a.we = w; bus_a.addr = a; bus_a.be = b; bus_a.wdata = wd;
      if (w) begin
        old = mem_a.exists(int'(a)) ? mem_a[int'(a)] : 32'h0;
        mem_a[int'(a)] = merge(old, wd, b);
      end else begin
        last_a = mem_a[int'(a)];
      end
      e.data = last_a;
      q_a.push_back(e);
    end else begin
      bus_b.req = 1'b1; bus_b.we = w; bus_b.addr = a; bus_b.be = b; bus_b.wdata = wd;
      if (w) begin
        old = mem_b.exists(int'(a)) ? mem_b[int'(a)] : 32'h0;
        mem_b[int'(a)] = merge(old, wd, b);
      end else begin
        last_b = mem_b[int'(a)];
      end
      e.data = last_b;
      q_b.push_back(e);
    end
    n = 0;
    while (!(d ? bus_b.ack : bus_a.ack) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("ack_timeout", 32'(d ? bus_b.ack : bus_a.ack), 32'd1);
    @(posedge clk); #1;
    if (!keep) begin
      if (!d) bus_a.req = 1'b0;
      else    bus_b.req = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    bus_a.req = 1'b0;
    bus_b.req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DEPTH-1:0] addrs [8];
    addrs = '{10'd0, 10'd1, 10'd6, 10'd8, 10'd10, 10'd511, 10'd1022, 10'd1023};

    bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.be = '0; bus_a.wdata = '0;
    bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.addr = '0; bus_b.be = '0; bus_b.wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ack_a", 32'(bus_a.ack), 32'd0);
    check("reset_rdata_a", bus_a.rdata, 32'd0);
    check("reset_stall_a", 32'(bus_a.stall), 32'd0);
    check("reset_ack_b", 32'(bus_b.ack), 32'd0);
    check("reset_rdata_b", bus_b.rdata, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Full-word write, then read back.
    access(0, 1, 10'd5, 4'hF, 32'hDEADBEEF, 0);
    access(0, 0, 10'd5, 4'h0, 32'h0, 0);
    check("t1_read5", bus_a.rdata, 32'hDEADBEEF);

    // Byte-lane merge.
    access(0, 1, 10'd7, 4'hF, 32'h11223344, 0);
    access(0, 1, 10'd7, 4'b0101, 32'hAABBCCDD, 0);
    access(0, 0, 10'd7, 4'h0, 32'h0, 0);
    check("t2_lanes", bus_a.rdata, 32'h11BB33DD);

    // Write with no byte enables leaves the word alone.
    access(0, 1, 10'd9, 4'hF, 32'h12345678, 0);
    access(0, 1, 10'd9, 4'h0, 32'hFFFFFFFF, 0);
    access(0, 0, 10'd9, 4'h0, 32'h0, 0);
    check("t5_be0", bus_a.rdata, 32'h12345678);

    // Back-to-back write/read/write; rdata holds across the second write.
    access(0, 1, 10'd2, 4'hF, 32'hCAFEF00D, 1);
    access(0, 0, 10'd2, 4'h0, 32'h0, 1);
    check("t6_raw", bus_a.rdata, 32'hCAFEF00D);
    access(0, 1, 10'd2, 4'hF, 32'h00000000, 0);
    check("t6_hold", bus_a.rdata, 32'hCAFEF00D);

    // Zero-wait instance: reads held high give ack every second cycle.
    access(1, 1, 10'd4, 4'hF, 32'hA5A50004, 0);
    access(1, 0, 10'd4, 4'h0, 32'h0, 1);
    access(1, 0, 10'd4, 4'h0, 32'h0, 1);
    access(1, 0, 10'd4, 4'h0, 32'h0, 1);
    access(1, 0, 10'd4, 4'h0, 32'h0, 0);
    check("t3_read4", bus_b.rdata, 32'hA5A50004);

    // Reset while a write is waiting: nothing is committed.
    access(0, 1, 10'd3, 4'hF, 32'h55AA55AA, 0);
    bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.addr = 10'd3; bus_a.be = 4'hF;
    bus_a.wdata = 32'h0BAD0BAD;
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    check("t4_ack_a", 32'(bus_a.ack), 32'd0);
    check("t4_rdata_a", bus_a.rdata, 32'd0);
    check("t4_rdata_b", bus_b.rdata, 32'd0);
    bus_a.req = 1'b0;
    last_a = '0;
    last_b = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    access(0, 0, 10'd3, 4'h0, 32'h0, 0);
    check("t4_mem3_old", bus_a.rdata, 32'h55AA55AA);

    // Randomised traffic over a pre-initialised address set on both instances.
    foreach (addrs[i]) begin
      access(0, 1, addrs[i], 4'hF, $urandom, 0);
      access(1, 1, addrs[i], 4'hF, $urandom, 0);
    end
    for (int k = 0; k < 120; k++) begin
      bit d;
      d = bit'($urandom_range(0, 1));
      access(d, bit'($urandom_range(0, 1)), addrs[$urandom_range(0, 7)],
             4'($urandom_range(0, 15)), $urandom, 0);
      idle(int'($urandom_range(0, 2)));
    end

    idle(5);
    check("q_a_drained", 32'(q_a.size()), 32'd0);
    check("q_b_drained", 32'(q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
